button_debouncer: RTL and testbench

- Upstream conditioning stage for the button-driven LED toggle logic.
- Synchronizes the raw asynchronous `button` pin into the `clk` domain and debounces it with a stability counter.
- Emits a clean level plus single-cycle press, release and long-press strobes; the toggle stage consumes `press_pulse` or `button_clean`.
- Single clock domain.

---
 rtl/button_debouncer.sv | 130 +++++++++++++
 tb/tb_button_debouncer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchronizer plus stability-counter debouncer.
// Produces a registered clean level and one-cycle press, release and
// long-press strobes for the downstream toggle logic.
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES     = 4,
  parameter int unsigned LONG_PRESS_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic button_clean,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  typedef enum logic [1:0] {
    RELEASED,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  localparam logic [7:0]  CNT_LAST  = 8'(STABLE_CYCLES - 1);
  localparam logic [15:0] LONG_LAST = 16'(LONG_PRESS_CYCLES - 1);

  state_t      state, state_n;
  logic        sync1, sync_q;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] long_cnt, long_cnt_n;
  logic        long_fired, long_fired_n;
  logic        clean_n, press_n, release_n, long_n;

  // Bring the raw pin into the clk domain; no logic between the flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      sync1  <= button;
      sync_q <= sync1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= RELEASED;
      cnt              <= '0;
      long_cnt         <= '0;
      long_fired       <= 1'b0;
      button_clean     <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      long_cnt         <= long_cnt_n;
      long_fired       <= long_fired_n;
      button_clean     <= clean_n;
      press_pulse      <= press_n;
      release_pulse    <= release_n;
      long_press_pulse <= long_n;
    end
  end

  // Next-state, counter and output decode; strobes default low each cycle.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    long_cnt_n   = long_cnt;
    long_fired_n = long_fired;
    clean_n      = button_clean;
    press_n      = 1'b0;
    release_n    = 1'b0;
    long_n       = 1'b0;
    unique case (state)
      RELEASED: begin
        if (sync_q) begin
          state_n = WAIT_PRESS;
          cnt_n   = 8'd1;
        end
      end
      WAIT_PRESS: begin
        if (!sync_q) begin
          state_n = RELEASED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n      = PRESSED;
          cnt_n        = '0;
          clean_n      = 1'b1;
          press_n      = 1'b1;
          long_cnt_n   = '0;
          long_fired_n = 1'b0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          state_n = WAIT_RELEASE;
          cnt_n   = 8'd1;
        end else begin
          if (long_cnt != '1) long_cnt_n = long_cnt + 16'd1;
          if (long_cnt == LONG_LAST && !long_fired) begin
            long_n       = 1'b1;
            long_fired_n = 1'b1;
          end
        end
      end
      WAIT_RELEASE: begin
        // Bounce back to PRESSED keeps the long-press progress intact.
        if (sync_q) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n   = RELEASED;
          cnt_n     = '0;
          clean_n   = 1'b0;
          release_n = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = RELEASED;
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer: directed scenarios plus random bouncy
// stimulus, checked cycle by cycle against a run-length reference model.
module tb_button_debouncer;

  localparam int unsigned STABLE = 4;
  localparam int unsigned LONG   = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic button = 1'b0;
  logic button_clean, press_pulse, release_pulse, long_press_pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0] exp_q[$];

  button_debouncer #(
    .STABLE_CYCLES(STABLE),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button(button),
    .button_clean(button_clean),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_press_pulse(long_press_pulse)
  );

  always #10 clk = ~clk;

  // Reference model: pin delayed two samples; the accepted level flips once
  // STABLE consecutive samples disagree with it. Long press counts held
  // samples since the press, ignoring samples that end a release attempt.
  logic    m_s1, m_s2, m_level, m_fired;
  int      m_run, m_hi;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_fired = 0; m_run = 0; m_hi = 0;
  endtask

  task automatic model_step(input logic b, output logic [3:0] e);
    logic samp, prs, rel, lng;
    int   prev_run;
    samp = m_s2; m_s2 = m_s1; m_s1 = b;
    prs = 0; rel = 0; lng = 0;
    prev_run = m_run;
    if (samp != m_level) m_run = m_run + 1; else m_run = 0;
    if (m_run == STABLE) begin
      m_level = samp;
      m_run = 0;
      if (samp) begin prs = 1; m_hi = 0; m_fired = 0; end
      else rel = 1;
    end else if (m_level && samp && prev_run == 0) begin
      if (m_hi < 65535) m_hi = m_hi + 1;
      if (m_hi == LONG && !m_fired) begin lng = 1; m_fired = 1; end
    end
    e = {m_level, prs, rel, lng};
  endtask

  // One clock of stimulus; r=1 holds reset (asserted mid-cycle if it was low).
  task automatic step(input logic b, input logic r);
    logic [3:0] e;
    @(negedge clk);
    button = b;
    if (r) begin
      if (!reset) begin
        #5 reset = 1'b1;
        #1;
        checks++;
        if ({button_clean, press_pulse, release_pulse, long_press_pulse} != 4'b0000) begin
          errors++;
          $display("FAIL async_reset_clear got %b want 0000", {button_clean, press_pulse, release_pulse, long_press_pulse});
        end
      end
      model_reset();
      e = 4'b0000;
    end else begin
      reset = 1'b0;
      model_step(b, e);
    end
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  // Monitor: after each rising edge, compare DUT outputs with the queued expectation.
  initial begin
    logic [3:0] got, want;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got = {button_clean, press_pulse, release_pulse, long_press_pulse};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL outputs cycle %0d got clean/press/rel/long=%b want %b", cyc, got, want);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout got no finish want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    model_reset();
    // Reset held over the first edges, then idle.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    hold(1'b0, 20);
    // Clean press, held long enough for one long press.
    hold(1'b1, 40);
    // Release with a one-cycle glitch mid-wait.
    hold(1'b0, 3);
    hold(1'b1, 1);
    hold(1'b0, 12);
    // Bounce before a steady press.
    for (int r = 0; r < 3; r++) begin
      hold(1'b1, 3);
      hold(1'b0, 1);
    end
    hold(1'b1, 40);
    // Release bounces while pressed; long-press progress must survive.
    hold(1'b0, 2);
    hold(1'b1, 5);
    hold(1'b0, 10);
    // Re-press with long press, then reset while pressed.
    hold(1'b1, 30);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    hold(1'b1, 12);
    hold(1'b0, 12);
    // Random bouncy runs with occasional resets.
    for (int k = 0; k < 400; k++) begin
      logic lvl;
      int n;
      lvl = 1'($urandom_range(0, 1));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 30)) : int'($urandom_range(1, 6));
      if ($urandom_range(0, 99) == 0) begin
        step(lvl, 1'b1);
        n = n - 1;
      end
      hold(lvl, n);
    end
    hold(1'b0, 10);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
